// File: rtl/dff_bank_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_seq_pkg
// Brief    : Shared state encoding and parameter limits for dff_bank_seq.
// Revision : 1.0  initial release
// ============================================================================
package dff_bank_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRIVE   = 2'd2,
    TURN    = 2'd3
  } state_t;

  localparam int HOLD_MAX = 255;
  localparam int TURN_MAX = 255;

endpackage
`default_nettype wire

// File: rtl/dff_bank_seq_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-input round-robin arbiter; last-winner register moves on upd.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic r_last;

  // On a tie the requester opposite the previous winner gets the bank.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (upd && (req != 2'b00)) begin
      r_last <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dff_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_seq
// Brief    : Arbitrated capture/drive/turnaround sequencer for a DFF bank.
//            Optional macro DFF_BANK_SEQ_POL_EN adds pol_i output inversion.
// Revision : 1.0  initial release
// ============================================================================
module dff_bank_seq #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
`ifdef DFF_BANK_SEQ_POL_EN
  input  logic [WIDTH-1:0] pol_i,
`endif
  output logic [1:0]       ack_o,
  output logic [1:0]       gnt_o,
  output logic [WIDTH-1:0] d_o,
  output logic             ce_o,
  output logic             oe_o,
  output logic             busy_o
);

  import dff_bank_seq_pkg::*;

  localparam int c_cnt_max = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_turn_load = c_cnt_w'(TURN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > HOLD_MAX) begin : g_hold_range_err
      $error("dff_bank_seq: HOLD_CYCLES out of range 1..255");
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES > TURN_MAX) begin : g_turn_range_err
      $error("dff_bank_seq: TURN_CYCLES out of range 1..255");
    end
  endgenerate

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           w_gnt;
  logic                 w_arb_upd;
  logic [WIDTH-1:0]     w_sel_data;
  logic [WIDTH-1:0]     w_cap_data;

  assign w_arb_upd  = (r_state == IDLE);
  assign w_sel_data = w_gnt[1] ? data1_i : data0_i;

`ifdef DFF_BANK_SEQ_POL_EN
  assign w_cap_data = w_sel_data ^ pol_i;
`else
  assign w_cap_data = w_sel_data;
`endif

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_i),
    .upd (w_arb_upd),
    .gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      ack_o   <= 2'b00;
      gnt_o   <= 2'b00;
      d_o     <= '0;
      ce_o    <= 1'b0;
      oe_o    <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_i != 2'b00) begin
            r_state <= CAPTURE;
            gnt_o   <= w_gnt;
            ack_o   <= w_gnt;
            d_o     <= w_cap_data;
            ce_o    <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        CAPTURE: begin
          r_state <= DRIVE;
          r_cnt   <= c_hold_load;
          ack_o   <= 2'b00;
          d_o     <= '0;
          ce_o    <= 1'b0;
          oe_o    <= 1'b1;
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            r_state <= TURN;
            r_cnt   <= c_turn_load;
            oe_o    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        TURN: begin
          // gnt_o stays with the owner so the bus turnaround is attributed.
          if (r_cnt == '0) begin
            r_state <= IDLE;
            gnt_o   <= 2'b00;
            busy_o  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_seq
// Brief    : Directed vector bench for dff_bank_seq (default and 1/1 timing).
// Revision : 1.0  initial release
// ============================================================================
module tb_dff_bank_seq;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] d0;
    logic [1:0] ack;
    logic [1:0] gnt;
    logic [3:0] d;
    logic       ce;
    logic       oe;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [1:0] req, req2;
  logic [3:0] d0, d1, pol;
  logic [1:0] ack, gnt, ack2, gnt2;
  logic [3:0] dout, dout2;
  logic       ce, oe, busy, ce2, oe2, busy2;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  always #5 clk = ~clk;

  dff_bank_seq #(.WIDTH(4), .HOLD_CYCLES(8), .TURN_CYCLES(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .data0_i (d0),
    .data1_i (d1),
`ifdef DFF_BANK_SEQ_POL_EN
    .pol_i   (pol),
`endif
    .ack_o   (ack),
    .gnt_o   (gnt),
    .d_o     (dout),
    .ce_o    (ce),
    .oe_o    (oe),
    .busy_o  (busy)
  );

  dff_bank_seq #(.WIDTH(4), .HOLD_CYCLES(1), .TURN_CYCLES(1)) dut2 (
    .clk     (clk),
    .rst     (rst2),
    .req_i   (req2),
    .data0_i (d0),
    .data1_i (d1),
`ifdef DFF_BANK_SEQ_POL_EN
    .pol_i   (pol),
`endif
    .ack_o   (ack2),
    .gnt_o   (gnt2),
    .d_o     (dout2),
    .ce_o    (ce2),
    .oe_o    (oe2),
    .busy_o  (busy2)
  );

  always @(negedge clk) begin
    if ((ce && oe) || (ce2 && oe2)) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic [1:0] rq, logic [3:0] a, logic [1:0] k,
                              logic [1:0] g, logic [3:0] dd, logic c, logic o, logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.d0 = a; v.ack = k; v.gnt = g;
    v.d = dd; v.ce = c; v.oe = o; v.busy = b;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int nack;
    int prev;
    logic [3:0] pol_exp;

    // Single requester-0 transaction with default timing, one row per edge.
    vecs[0] = mk(1'b1, 2'b00, 4'h0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 2'b01, 4'hA, 2'b01, 2'b01, 4'hA, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 9; i++)
      vecs[i] = mk(1'b0, 2'b00, 4'hA, 2'b00, 2'b01, 4'h0, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(1'b0, 2'b00, 4'hA, 2'b00, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 2'b00, 4'hA, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 2'b00, 4'hA, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; rst2 = 1'b1; req = 2'b00; req2 = 2'b00;
    d0 = 4'h0; d1 = 4'h0; pol = 4'h0;

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      d0  = vecs[i].d0;
      step();
      chk($sformatf("vec%0d_ack", i),  ack,  vecs[i].ack);
      chk($sformatf("vec%0d_gnt", i),  gnt,  vecs[i].gnt);
      chk($sformatf("vec%0d_d", i),    dout, vecs[i].d);
      chk($sformatf("vec%0d_ce", i),   ce,   vecs[i].ce);
      chk($sformatf("vec%0d_oe", i),   oe,   vecs[i].oe);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // Both requesting continuously: grants alternate 0,1,0,1 every 11 cycles.
    rst = 1'b1; req = 2'b00; step();
    rst = 1'b0; d0 = 4'h3; d1 = 4'hC; req = 2'b11;
    nack = 0; prev = 0;
    for (int c = 1; c <= 60 && nack < 4; c++) begin
      step();
      if (ack != 2'b00) begin
        chk($sformatf("alt%0d_ack", nack), ack, (nack % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("alt%0d_d", nack), dout, (nack % 2 == 0) ? 4'h3 : 4'hC);
        if (nack > 0) chk($sformatf("alt%0d_gap", nack), c - prev, 11);
        prev = c;
        nack++;
      end
    end
    chk("alt_count", nack, 4);
    req = 2'b00;

    // Reset in the middle of DRIVE aborts cleanly and restores the tie order.
    rst = 1'b1; step();
    rst = 1'b0; d0 = 4'h6; req = 2'b01; step();
    req = 2'b00; step(); step(); step();
    chk("rstmid_pre_oe", oe, 1'b1);
    rst = 1'b1; step();
    chk("rstmid_oe", oe, 1'b0);
    chk("rstmid_gnt", gnt, 2'b00);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ack", ack, 2'b00);
    rst = 1'b0; d0 = 4'h9; d1 = 4'h2; req = 2'b11; step();
    chk("rstmid_tie_ack", ack, 2'b01);
    chk("rstmid_tie_d", dout, 4'h9);
    req = 2'b00;

    // Requester 1 arrives during requester 0's DRIVE window.
    rst = 1'b1; step();
    rst = 1'b0; d0 = 4'h1; d1 = 4'hB; req = 2'b01; step();
    chk("late_first_ack", ack, 2'b01);
    req = 2'b10;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("late_noack%0d", i), ack, 2'b00);
    end
    chk("late_idle_busy", busy, 1'b0);
    step();
    chk("late_ack", ack, 2'b10);
    chk("late_gnt", gnt, 2'b10);
    chk("late_d", dout, 4'hB);
    req = 2'b00;

    // Polarity path (plain pass-through when the option is not built in).
    rst = 1'b1; step();
`ifdef DFF_BANK_SEQ_POL_EN
    pol_exp = 4'hA;
`else
    pol_exp = 4'hF;
`endif
    rst = 1'b0; pol = 4'b0101; d1 = 4'hF; req = 2'b10; step();
    chk("pol_ack", ack, 2'b10);
    chk("pol_d", dout, pol_exp);
    req = 2'b00; pol = 4'h0;

    // Minimum timing: HOLD=1, TURN=1, held request recaptured 4 cycles later.
    d0 = 4'h5;
    rst2 = 1'b1; step();
    rst2 = 1'b0; req2 = 2'b01; step();
    chk("min_cap_ack", ack2, 2'b01);
    chk("min_cap_ce", ce2, 1'b1);
    step();
    chk("min_drive_oe", oe2, 1'b1);
    chk("min_drive_ce", ce2, 1'b0);
    step();
    chk("min_turn_oe", oe2, 1'b0);
    chk("min_turn_gnt", gnt2, 2'b01);
    chk("min_turn_busy", busy2, 1'b1);
    step();
    chk("min_idle_busy", busy2, 1'b0);
    chk("min_idle_ack", ack2, 2'b00);
    step();
    chk("min_recap_ack", ack2, 2'b01);
    chk("min_recap_d", dout2, 4'h5);
    req2 = 2'b00;
    step();

    chk("ce_oe_overlap", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
